mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_arbiter
//  Purpose  : Two-port (instruction fetch / load-store) arbiter onto a single
//             shared memory bus with one outstanding transaction, data
//             priority, fetch anti-starvation and pipeline-flush handling.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,

  // Instruction-fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,

  // Load/store port
  input  logic        data_req,
  input  logic        data_we,
  input  logic [3:0]  data_sel,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ack,

  // Shared memory bus
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,

  // Pipeline stall requests
  output logic        stallreq_if,
  output logic        stallreq_data
);

  // Counter wide enough to hold STARVE_MAX (at least one bit).
  localparam int unsigned        c_CNT_W      = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_MAX);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    BUSY_IF   = 3'd1,
    BUSY_DATA = 3'd2,
    DRAIN     = 3'd3,
    RESP_IF   = 3'd4,
    RESP_DATA = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [c_CNT_W-1:0]   r_starve_cnt;
  logic                 r_mem_req;
  logic                 r_mem_we;
  logic [3:0]           r_mem_sel;
  logic [31:0]          r_mem_addr;
  logic [31:0]          r_mem_wdata;
  logic [31:0]          r_if_rdata;
  logic [31:0]          r_data_rdata;

  logic                 w_fetch_ok;
  logic                 w_starved;
  logic                 w_grant_if;
  logic                 w_grant_data;
  logic                 w_ld_if_rdata;
  logic                 w_ld_data_rdata;
  logic                 w_mem_req_clr;

  // A fetch may only be granted when no flush is cancelling fetch traffic.
  assign w_fetch_ok = if_req & ~flush;
  // Fetch has waited through the maximum number of consecutive data grants.
  assign w_starved  = (r_starve_cnt == c_STARVE_MAX);

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and per-cycle control strobes.
  always_comb begin
    w_state_nxt     = r_state;
    w_grant_if      = 1'b0;
    w_grant_data    = 1'b0;
    w_ld_if_rdata   = 1'b0;
    w_ld_data_rdata = 1'b0;
    w_mem_req_clr   = 1'b0;

    case (r_state)
      IDLE: begin
        // Data wins unless fetch has been starved; a flushed fetch never wins.
        if (w_fetch_ok && (!data_req || w_starved)) begin
          w_grant_if  = 1'b1;
          w_state_nxt = BUSY_IF;
        end else if (data_req) begin
          w_grant_data = 1'b1;
          w_state_nxt  = BUSY_DATA;
        end
      end

      BUSY_IF: begin
        if (mem_ack) begin
          w_mem_req_clr = 1'b1;
          // A flush arriving with the bus ack simply discards the response.
          if (flush) begin
            w_state_nxt = IDLE;
          end else begin
            w_ld_if_rdata = 1'b1;
            w_state_nxt   = RESP_IF;
          end
        end else if (flush) begin
          // The bus transaction cannot be aborted; wait it out silently.
          w_state_nxt = DRAIN;
        end
      end

      BUSY_DATA: begin
        if (mem_ack) begin
          w_mem_req_clr   = 1'b1;
          // Stores must not disturb the last load result.
          w_ld_data_rdata = ~r_mem_we;
          w_state_nxt     = RESP_DATA;
        end
      end

      DRAIN: begin
        if (mem_ack) begin
          w_mem_req_clr = 1'b1;
          w_state_nxt   = IDLE;
        end
      end

      RESP_IF:   w_state_nxt = IDLE;
      RESP_DATA: w_state_nxt = IDLE;

      default:   w_state_nxt = IDLE;
    endcase
  end

  // Anti-starvation counter: counts data grants that overtook a waiting fetch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_starve_cnt <= '0;
    end else if (w_grant_if) begin
      r_starve_cnt <= '0;
    end else if (w_grant_data && if_req && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // Bus request: raised on a grant, held until the bus acknowledges.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mem_req <= 1'b0;
    end else if (w_grant_if || w_grant_data) begin
      r_mem_req <= 1'b1;
    end else if (w_mem_req_clr) begin
      r_mem_req <= 1'b0;
    end
  end

  // Bus command fields: captured from the winning port, frozen until next grant.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mem_we    <= 1'b0;
      r_mem_sel   <= 4'h0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
    end else if (w_grant_if) begin
      r_mem_we    <= 1'b0;
      r_mem_sel   <= 4'hF;
      r_mem_addr  <= if_addr;
      r_mem_wdata <= 32'h0;
    end else if (w_grant_data) begin
      r_mem_we    <= data_we;
      r_mem_sel   <= data_sel;
      r_mem_addr  <= data_addr;
      r_mem_wdata <= data_wdata;
    end
  end

  // Per-port read data: updated only by a completed response to that port.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_if_rdata   <= 32'h0;
      r_data_rdata <= 32'h0;
    end else begin
      if (w_ld_if_rdata) begin
        r_if_rdata <= mem_rdata;
      end
      if (w_ld_data_rdata) begin
        r_data_rdata <= mem_rdata;
      end
    end
  end

  // Acks are decoded from the response states; flush masks a fetch response.
  assign if_ack        = (r_state == RESP_IF) & ~flush;
  assign data_ack      = (r_state == RESP_DATA);

  assign stallreq_if   = if_req   & ~if_ack;
  assign stallreq_data = data_req & ~data_ack;

  assign if_rdata      = r_if_rdata;
  assign data_rdata    = r_data_rdata;

  assign mem_req       = r_mem_req;
  assign mem_we        = r_mem_we;
  assign mem_sel       = r_mem_sel;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bus_arbiter
//  Purpose  : Directed self-checking bench for mem_bus_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_sel;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_ack;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stallreq_if;
  logic        stallreq_data;

  int n_chk;
  int n_pass;

  mem_bus_arbiter #(.STARVE_MAX(3)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .flush         (flush),
    .if_req        (if_req),
    .if_addr       (if_addr),
    .if_rdata      (if_rdata),
    .if_ack        (if_ack),
    .data_req      (data_req),
    .data_we       (data_we),
    .data_sel      (data_sel),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .data_rdata    (data_rdata),
    .data_ack      (data_ack),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_sel       (mem_sel),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .stallreq_if   (stallreq_if),
    .stallreq_data (stallreq_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports any mismatch.
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Move to the next cycle; inputs are driven 2ns after the rising edge.
  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  // One complete transaction starting from an IDLE cycle with requests set.
  task automatic serve(input logic exp_if, input logic [31:0] exp_addr, input logic [31:0] rd);
    nxt(); #1;
    check("srv_req",  32'(mem_req), 32'd1);
    check("srv_we",   32'(mem_we),  32'd0);
    check("srv_addr", mem_addr,     exp_addr);
    nxt(); mem_ack = 1'b1; mem_rdata = rd; #1;
    nxt(); mem_ack = 1'b0; #1;
    check("srv_if_ack",   32'(if_ack),   32'(exp_if));
    check("srv_data_ack", 32'(data_ack), 32'(!exp_if));
    if (exp_if) check("srv_if_rdata",   if_rdata,   rd);
    else        check("srv_data_rdata", data_rdata, rd);
    nxt(); #1;
    check("srv_idle_req", 32'(mem_req), 32'd0);
  endtask

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    resetn     = 1'b0;
    flush      = 1'b0;
    if_req     = 1'b0;
    if_addr    = 32'h0;
    data_req   = 1'b0;
    data_we    = 1'b0;
    data_sel   = 4'h0;
    data_addr  = 32'h0;
    data_wdata = 32'h0;
    mem_rdata  = 32'h0;
    mem_ack    = 1'b0;

    // ---------------- reset state ----------------
    #1;
    check("rst_mem_req",  32'(mem_req),  32'd0);
    check("rst_if_ack",   32'(if_ack),   32'd0);
    check("rst_data_ack", 32'(data_ack), 32'd0);
    check("rst_mem_addr", mem_addr,      32'h0);
    @(posedge clk);
    @(posedge clk);
    #4 resetn = 1'b1;

    // ---------------- single fetch, bus latency 1 ----------------
    nxt(); if_req = 1'b1; if_addr = 32'h100; #1;
    check("f1_stall0",  32'(stallreq_if), 32'd1);
    check("f1_req0",    32'(mem_req),     32'd0);
    nxt(); #1;
    check("f1_req1",    32'(mem_req), 32'd1);
    check("f1_addr",    mem_addr,     32'h100);
    check("f1_we",      32'(mem_we),  32'd0);
    nxt(); mem_ack = 1'b1; mem_rdata = 32'h3C010001; #1;
    check("f1_stall2",  32'(stallreq_if), 32'd1);
    check("f1_noack",   32'(if_ack),      32'd0);
    nxt(); mem_ack = 1'b0; #1;
    check("f1_ack",     32'(if_ack),      32'd1);
    check("f1_rdata",   if_rdata,         32'h3C010001);
    check("f1_stall3",  32'(stallreq_if), 32'd0);
    check("f1_reqdrop", 32'(mem_req),     32'd0);
    nxt(); if_req = 1'b0; #1;
    check("f1_ackpulse", 32'(if_ack), 32'd0);

    // ---------------- simultaneous store + fetch ----------------
    nxt();
    if_req = 1'b1; if_addr = 32'h104;
    data_req = 1'b1; data_we = 1'b1; data_sel = 4'hF;
    data_addr = 32'h200; data_wdata = 32'hDEADBEEF;
    #1;
    check("s_stall_d", 32'(stallreq_data), 32'd1);
    nxt(); #1;
    check("s_req",   32'(mem_req), 32'd1);
    check("s_we",    32'(mem_we),  32'd1);
    check("s_addr",  mem_addr,     32'h200);
    check("s_sel",   32'(mem_sel), 32'hF);
    check("s_wdata", mem_wdata,    32'hDEADBEEF);
    nxt(); mem_ack = 1'b1; mem_rdata = 32'h12345678; #1;
    nxt(); mem_ack = 1'b0; #1;
    check("s_dack",    32'(data_ack), 32'd1);
    check("s_noifack", 32'(if_ack),   32'd0);
    check("s_rd_keep", data_rdata,    32'h0);
    nxt(); data_req = 1'b0; data_we = 1'b0; #1;
    check("s_dack_pulse", 32'(data_ack), 32'd0);
    check("s_resp_nogrant", 32'(mem_req), 32'd0);
    nxt(); #1;
    check("s_f_req",  32'(mem_req), 32'd1);
    check("s_f_addr", mem_addr,     32'h104);
    nxt(); mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D; #1;
    nxt(); mem_ack = 1'b0; #1;
    check("s_f_ack",   32'(if_ack), 32'd1);
    check("s_f_rdata", if_rdata,    32'hCAFEF00D);
    nxt(); if_req = 1'b0; #1;

    // ---------------- starvation: D D D F D D D F ----------------
    nxt();
    if_req = 1'b1; if_addr = 32'h300;
    data_req = 1'b1; data_we = 1'b0; data_sel = 4'hF; data_addr = 32'h400;
    #1;
    for (int i = 0; i < 8; i++) begin
      serve(((i % 4) == 3), ((i % 4) == 3) ? 32'h300 : 32'h400, 32'hA0000000 + 32'(i));
    end

    // ---------------- flush during BUSY_IF -> DRAIN ----------------
    data_req = 1'b0; if_addr = 32'h500;
    nxt(); flush = 1'b1; #1;
    check("d_req",  32'(mem_req), 32'd1);
    check("d_addr", mem_addr,     32'h500);
    nxt();
    flush = 1'b0; if_req = 1'b0;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h600;
    #1;
    check("d_hold0", 32'(mem_req), 32'd1);
    check("d_noack", 32'(if_ack),  32'd0);
    nxt(); #1;
    check("d_hold1", 32'(mem_req), 32'd1);
    check("d_nodgr", mem_addr,     32'h500);
    nxt(); #1;
    check("d_hold2", 32'(mem_req), 32'd1);
    nxt(); mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0; #1;
    check("d_noack2", 32'(if_ack), 32'd0);
    nxt(); mem_ack = 1'b0; #1;
    check("d_done_req", 32'(mem_req), 32'd0);
    check("d_done_ack", 32'(if_ack),  32'd0);
    check("d_rd_keep",  if_rdata,     32'hA0000007);
    check("d_no_dack",  32'(data_ack), 32'd0);
    nxt(); #1;
    check("d_next_req",  32'(mem_req), 32'd1);
    check("d_next_addr", mem_addr,     32'h600);
    nxt(); mem_ack = 1'b1; mem_rdata = 32'h600D600D; #1;
    nxt(); mem_ack = 1'b0; #1;
    check("d_ld_ack",   32'(data_ack), 32'd1);
    check("d_ld_rdata", data_rdata,    32'h600D600D);
    nxt(); data_req = 1'b0; #1;

    // ---------------- flush in IDLE blocks fetch; flush in RESP_IF ----------------
    nxt(); if_req = 1'b1; if_addr = 32'h700; flush = 1'b1; #1;
    check("g_req0", 32'(mem_req), 32'd0);
    nxt(); flush = 1'b0; #1;
    check("g_nogrant", 32'(mem_req), 32'd0);
    nxt(); #1;
    check("g_req",  32'(mem_req), 32'd1);
    check("g_addr", mem_addr,     32'h700);
    nxt(); mem_ack = 1'b1; mem_rdata = 32'h77777777; #1;
    nxt(); mem_ack = 1'b0; flush = 1'b1; #1;
    check("g_suppress", 32'(if_ack),      32'd0);
    check("g_stall",    32'(stallreq_if), 32'd1);
    nxt(); flush = 1'b0; if_req = 1'b0; #1;
    check("g_idle_req", 32'(mem_req), 32'd0);
    check("g_idle_ack", 32'(if_ack),  32'd0);

    // ---------------- reset during BUSY_DATA ----------------
    nxt();
    data_req = 1'b1; data_we = 1'b1; data_sel = 4'h3;
    data_addr = 32'h800; data_wdata = 32'h11223344;
    #1;
    nxt(); #1;
    check("r_busy_req", 32'(mem_req), 32'd1);
    check("r_busy_sel", 32'(mem_sel), 32'h3);
    #1 resetn = 1'b0;
    #1;
    check("r_mem_req",   32'(mem_req),  32'd0);
    check("r_mem_we",    32'(mem_we),   32'd0);
    check("r_mem_sel",   32'(mem_sel),  32'd0);
    check("r_mem_addr",  mem_addr,      32'h0);
    check("r_mem_wdata", mem_wdata,     32'h0);
    check("r_if_rdata",  if_rdata,      32'h0);
    check("r_d_rdata",   data_rdata,    32'h0);
    check("r_d_ack",     32'(data_ack), 32'd0);
    data_req = 1'b0; data_we = 1'b0;
    nxt(); mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF; #1;
    check("r_held_req", 32'(mem_req), 32'd0);
    #2 resetn = 1'b1;
    nxt(); #1;
    check("r_spur_req",  32'(mem_req),  32'd0);
    check("r_spur_dack", 32'(data_ack), 32'd0);
    nxt(); mem_ack = 1'b0; #1;
    check("r_after_dack",  32'(data_ack), 32'd0);
    check("r_after_ifack", 32'(if_ack),   32'd0);
    check("r_after_rdata", data_rdata,    32'h0);
    check("r_after_req",   32'(mem_req),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
